// File: rtl/rs232_pkg.sv
// Shared types and ASCII constants for the serial hex loader.
package rs232_pkg;

  localparam int unsigned BCNT_W = 16;

  typedef enum logic [1:0] {
    DATA_HI = 2'd0,
    DATA_LO = 2'd1,
    ADDR    = 2'd2,
    COMMENT = 2'd3
  } state_e;

  localparam logic [7:0] CH_AT   = 8'h40;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_TAB  = 8'h09;

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII classifier: hex digit value and whitespace detect.
module hex_char_decode
  import rs232_pkg::*;
(
  input  logic [7:0] ch_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o,
  output logic       is_ws_o
);

  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'h0;
    if (ch_i >= 8'h30 && ch_i <= 8'h39) begin
      is_hex_o = 1'b1;
      nibble_o = 4'(ch_i - 8'h30);
    end else if (ch_i >= 8'h41 && ch_i <= 8'h46) begin
      is_hex_o = 1'b1;
      nibble_o = 4'(ch_i - 8'h37);
    end else if (ch_i >= 8'h61 && ch_i <= 8'h66) begin
      is_hex_o = 1'b1;
      nibble_o = 4'(ch_i - 8'h57);
    end
  end

  assign is_ws_o = (ch_i == CH_SP) || (ch_i == CH_TAB) ||
                   (ch_i == CH_CR) || (ch_i == CH_LF);

endmodule

// File: rtl/rs232_hex_loader.sv
// Parses "@AAAA" / hex-pair / '#' comment text from the UART into memory writes.
module rs232_hex_loader
  import rs232_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_strobe,
  input  logic [7:0]        rx_byte,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              err_syntax,
  output logic              err_overrun,
  input  logic              err_clear,
  output logic [BCNT_W-1:0] byte_count
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          nib_q, nib_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                err_syntax_q, err_syntax_d;
  logic                err_overrun_q, err_overrun_d;
  logic [BCNT_W-1:0]   byte_count_q, byte_count_d;
  logic                busy_q, busy_d;

  logic       is_hex, is_ws;
  logic [3:0] nibble;
  logic       syn_ev, ovr_ev, complete;

  hex_char_decode u_dec (
    .ch_i     (rx_byte),
    .is_hex_o (is_hex),
    .nibble_o (nibble),
    .is_ws_o  (is_ws)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    nib_d         = nib_q;
    wr_valid_d    = wr_valid_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    byte_count_d  = byte_count_q;
    syn_ev        = 1'b0;
    ovr_ev        = 1'b0;
    complete      = 1'b0;

    if (wr_valid_q && wr_ready) begin
      wr_valid_d   = 1'b0;
      byte_count_d = byte_count_q + BCNT_W'(1);
    end

    if (rx_strobe) begin
      unique case (state_q)
        DATA_HI: begin
          if (is_hex) begin
            nib_d   = nibble;
            state_d = DATA_LO;
          end else if (is_ws) begin
            state_d = DATA_HI;
          end else if (rx_byte == CH_AT) begin
            addr_d  = '0;
            state_d = ADDR;
          end else if (rx_byte == CH_HASH) begin
            state_d = COMMENT;
          end else begin
            syn_ev = 1'b1;
          end
        end
        DATA_LO: begin
          state_d = DATA_HI;
          if (is_hex) begin
            complete = 1'b1;
          end else begin
            syn_ev = 1'b1;
            if (rx_byte == CH_AT) begin
              addr_d  = '0;
              state_d = ADDR;
            end else if (rx_byte == CH_HASH) begin
              state_d = COMMENT;
            end
          end
        end
        ADDR: begin
          if (is_hex) begin
            addr_d = {addr_q[ADDR_W-5:0], nibble};
          end else if (is_ws) begin
            state_d = DATA_HI;
          end else if (rx_byte == CH_AT) begin
            addr_d = '0;
          end else if (rx_byte == CH_HASH) begin
            state_d = COMMENT;
          end else begin
            syn_ev  = 1'b1;
            state_d = DATA_HI;
          end
        end
        COMMENT: begin
          if (rx_byte == CH_LF) state_d = DATA_HI;
        end
      endcase
    end

    // A completed byte either launches (slot free or freed this cycle) or is
    // dropped as an overrun; the address advances in both cases.
    if (complete) begin
      if (!wr_valid_q || wr_ready) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = addr_q;
        wr_data_d  = {nib_q, nibble};
      end else begin
        ovr_ev = 1'b1;
      end
      addr_d = addr_q + ADDR_W'(1);
    end

    err_syntax_d  = (err_syntax_q  && !err_clear) || syn_ev;
    err_overrun_d = (err_overrun_q && !err_clear) || ovr_ev;
    busy_d        = (state_d != DATA_HI) || wr_valid_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= DATA_HI;
      addr_q        <= '0;
      nib_q         <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      err_syntax_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      byte_count_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      nib_q         <= nib_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      err_syntax_q  <= err_syntax_d;
      err_overrun_q <= err_overrun_d;
      byte_count_q  <= byte_count_d;
      busy_q        <= busy_d;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign err_syntax  = err_syntax_q;
  assign err_overrun = err_overrun_q;
  assign byte_count  = byte_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rs232_hex_loader.sv
// Scoreboard bench for rs232_hex_loader: directed text, expected writes queued.
module tb_rs232_hex_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_strobe = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        err_syntax;
  logic        err_overrun;
  logic        err_clear = 1'b0;
  logic [15:0] byte_count;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];

  rs232_hex_loader #(.ADDR_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_strobe   (rx_strobe),
    .rx_byte     (rx_byte),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .err_syntax  (err_syntax),
    .err_overrun (err_overrun),
    .err_clear   (err_clear),
    .byte_count  (byte_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake seen before the accepting edge pops one expectation.
  always @(negedge clock) begin
    if (reset_n && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'h00, wr_addr, wr_data}, 32'hFFFF_FFFF);
      end else begin
        chk("write", {8'h00, wr_addr, wr_data}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    rx_strobe = 1'b0;
    err_clear = 1'b0;
    wr_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic send_char(input byte c);
    rx_strobe = 1'b1;
    rx_byte = c;
    @(posedge clock); #1;
    rx_strobe = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (wr_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk(name, 32'(wr_valid), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    do_reset();
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errs", {30'd0, err_syntax, err_overrun}, 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);

    // Basic pairs with one-cycle latency from the second digit
    exp_q.push_back({16'h0010, 8'h41});
    exp_q.push_back({16'h0011, 8'h4A});
    send_str("@0010 ");
    chk("t1_busy_idle", 32'(busy), 32'd0);
    send_char("4");
    chk("t1_busy_lo", 32'(busy), 32'd1);
    @(posedge clock); #1;
    send_char("1");
    chk("t1_lat1", 32'(wr_valid), 32'd1);
    @(posedge clock); #1;
    send_str(" 4");
    send_char("a");
    chk("t1_lat2", 32'(wr_valid), 32'd1);
    @(posedge clock); #1;
    send_char(8'h0A);
    wait_idle("t1_drain");
    chk("t1_count", 32'(byte_count), 32'd2);
    chk("t1_errs", {30'd0, err_syntax, err_overrun}, 32'd0);

    // Excess address digits shift out
    do_reset();
    exp_q.push_back({16'h2345, 8'hFF});
    send_str("@12345 ff");
    wait_idle("t2_drain");
    chk("t2_count", 32'(byte_count), 32'd1);

    // Address wrap
    do_reset();
    exp_q.push_back({16'hFFFF, 8'h01});
    exp_q.push_back({16'h0000, 8'h02});
    send_str("@FFFF 01 02");
    wait_idle("t3_drain");
    chk("t3_count", 32'(byte_count), 32'd2);
    chk("t3_syntax", 32'(err_syntax), 32'd0);

    // Comment swallowed up to LF
    do_reset();
    exp_q.push_back({16'h0000, 8'hAB});
    send_str("# @99 zz\nAb");
    wait_idle("t4_drain");
    chk("t4_count", 32'(byte_count), 32'd1);
    chk("t4_syntax", 32'(err_syntax), 32'd0);

    // Odd nibble and illegal char, then clear and clear-vs-error priority
    do_reset();
    send_str("4 ");
    chk("t5_odd_nibble", 32'(err_syntax), 32'd1);
    send_str("5G");
    chk("t5_no_write", {31'd0, wr_valid}, 32'd0);
    chk("t5_count", 32'(byte_count), 32'd0);
    chk("t5_syntax", 32'(err_syntax), 32'd1);
    err_clear = 1'b1;
    @(posedge clock); #1;
    err_clear = 1'b0;
    chk("t5_cleared", 32'(err_syntax), 32'd0);
    rx_strobe = 1'b1; rx_byte = "G"; err_clear = 1'b1;
    @(posedge clock); #1;
    rx_strobe = 1'b0; err_clear = 1'b0;
    chk("t5_err_wins", 32'(err_syntax), 32'd1);

    // Overrun under backpressure
    do_reset();
    wr_ready = 1'b0;
    exp_q.push_back({16'h0000, 8'h11});
    send_str("11");
    chk("t6_pending", {15'd0, wr_valid, wr_addr}, {15'd0, 1'b1, 16'h0000});
    send_str("22");
    chk("t6_stable", {7'd0, wr_valid, wr_addr, wr_data}, {7'd0, 1'b1, 16'h0000, 8'h11});
    chk("t6_overrun", 32'(err_overrun), 32'd1);
    wr_ready = 1'b1;
    wait_idle("t6_drain1");
    chk("t6_count1", 32'(byte_count), 32'd1);
    exp_q.push_back({16'h0002, 8'h33});
    send_str("33");
    wait_idle("t6_drain2");
    chk("t6_count2", 32'(byte_count), 32'd2);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
